// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: one-entry pipeline register, load extension, register-file write port,
// decode forwarding tap and commit pulse. Define MEMWB_PERF_CNT_EN to build the retire/load counters.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  exe_to_mem_valid,
  output logic                                  mem_to_exe_ready,
  input  logic [2*DATA_WIDTH+REG_ADDR_WIDTH+3:0] exe_to_mem_bus,
  input  logic                                  wb_stall,
  output logic                                  rf_we,
  output logic [REG_ADDR_WIDTH-1:0]             rf_waddr,
  output logic [DATA_WIDTH-1:0]                 rf_wdata,
  output logic                                  fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0]             fwd_addr,
  output logic [DATA_WIDTH-1:0]                 fwd_data,
  output logic                                  wb_commit,
  output logic [63:0]                           perf_retire_cnt,
  output logic [63:0]                           perf_load_cnt
);

  localparam int unsigned BUS_W = 2*DATA_WIDTH + REG_ADDR_WIDTH + 4;

  typedef enum logic [2:0] {
    LD_NONE = 3'h0,
    LD_B    = 3'h1,
    LD_H    = 3'h2,
    LD_W    = 3'h3,
    LD_BU   = 3'h4,
    LD_HU   = 3'h5
  } load_t;

  logic                      in_regw;
  logic [REG_ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0]     in_alu;
  logic [2:0]                in_load_inst;
  logic [DATA_WIDTH-1:0]     in_load_data;
  logic [DATA_WIDTH-1:0]     in_result;

  logic                      wb_valid;
  logic                      wb_regw;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_result;

  logic wb_fire;
  logic accept;
  logic writes_reg;

  assign in_regw      = exe_to_mem_bus[BUS_W-1];
  assign in_addr      = exe_to_mem_bus[2*DATA_WIDTH+REG_ADDR_WIDTH+2:2*DATA_WIDTH+3];
  assign in_alu       = exe_to_mem_bus[2*DATA_WIDTH+2:DATA_WIDTH+3];
  assign in_load_inst = exe_to_mem_bus[DATA_WIDTH+2:DATA_WIDTH];
  assign in_load_data = exe_to_mem_bus[DATA_WIDTH-1:0];

  // Encodings 6 and 7 fall into the default arm and behave as LW.
  always_comb begin
    in_result = in_load_data;
    case (load_t'(in_load_inst))
      LD_NONE: in_result = in_alu;
      LD_B:    in_result = {{(DATA_WIDTH-8){in_load_data[7]}}, in_load_data[7:0]};
      LD_H:    in_result = {{(DATA_WIDTH-16){in_load_data[15]}}, in_load_data[15:0]};
      LD_BU:   in_result = {{(DATA_WIDTH-8){1'b0}}, in_load_data[7:0]};
      LD_HU:   in_result = {{(DATA_WIDTH-16){1'b0}}, in_load_data[15:0]};
      default: in_result = in_load_data;
    endcase
  end

  assign wb_fire          = wb_valid & ~wb_stall;
  assign mem_to_exe_ready = ~wb_valid | wb_fire;
  assign accept           = exe_to_mem_valid & mem_to_exe_ready;
  assign writes_reg       = wb_regw & (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid  <= 1'b0;
      wb_regw   <= 1'b0;
      wb_addr   <= '0;
      wb_result <= '0;
    end else if (accept) begin
      wb_valid  <= 1'b1;
      wb_regw   <= in_regw;
      wb_addr   <= in_addr;
      wb_result <= in_result;
    end else if (wb_fire) begin
      wb_valid  <= 1'b0;
    end
  end

  assign rf_we     = wb_fire & writes_reg;
  assign rf_waddr  = wb_addr;
  assign rf_wdata  = wb_result;
  assign fwd_valid = wb_valid & writes_reg;
  assign fwd_addr  = wb_addr;
  assign fwd_data  = wb_result;
  assign wb_commit = wb_fire;

`ifdef MEMWB_PERF_CNT_EN
  logic        wb_is_load;
  logic [63:0] retire_cnt;
  logic [63:0] load_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_is_load <= 1'b0;
      retire_cnt <= '0;
      load_cnt   <= '0;
    end else begin
      if (accept) wb_is_load <= (in_load_inst != 3'h0);
      if (wb_fire) begin
        retire_cnt <= retire_cnt + 64'd1;
        if (wb_is_load) load_cnt <= load_cnt + 64'd1;
      end
    end
  end

  assign perf_retire_cnt = retire_cnt;
  assign perf_load_cnt   = load_cnt;
`else
  assign perf_retire_cnt = '0;
  assign perf_load_cnt   = '0;
`endif

endmodule
